// File: rtl/wb_slave_mem.sv
// wb_slave_mem: Wishbone B3 classic-cycle slave memory.
//
// Responder end of the bus. Each accepted request is latched together with its
// own wait-state count. It then terminates with exactly one ack or err pulse.
// Illegal accesses terminate with err: an out-of-window address or an empty
// byte select. Saturating counters report the completed reads, writes and errors.
//
// Ports
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   wb_adr_i/dat_i/sel_i/we_i/cyc_i/stb_i   request from the master
//   wb_dat_o, wb_ack_o, wb_err_o            response to the master
//   ws_i                 wait states for the request being accepted
//   rd_cnt_o, wr_cnt_o, err_cnt_o           saturating access counters
module wb_slave_mem #(
  parameter int          MEM_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  input  logic [3:0]       ws_i,
  output logic [CNT_W-1:0] rd_cnt_o,
  output logic [CNT_W-1:0] wr_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);
  localparam int          AW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [31:0] SPAN = 32'(4 * MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           r_state;
  logic [31:0]      r_adr, r_dat, r_rdata;
  logic [3:0]       r_sel, r_ws;
  logic             r_we, r_ack, r_err;
  logic [CNT_W-1:0] r_rd_cnt, r_wr_cnt, r_err_cnt;
  logic [31:0]      r_mem [MEM_DEPTH];

  logic [31:0]      w_off;
  logic             w_legal;
  logic [AW-1:0]    w_idx;
  logic             w_wr_en;

  // The offset compare uses all 32 bits. An address below BASE_ADDR wraps to a
  // huge unsigned offset and so also fails the window check.
  assign w_off   = r_adr - BASE_ADDR;
  assign w_legal = (w_off < SPAN) && (r_sel != 4'b0000);
  assign w_idx   = w_off[AW+1:2];
  // The write lands on the same edge that raises ack. A reset on that edge
  // discards the write.
  assign w_wr_en = (r_state == RESP) && w_legal && r_we && !wb_rst_i;

  // The storage array is kept out of the reset domain, so reset leaves its contents intact.
  always_ff @(posedge wb_clk_i) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (r_sel[b]) r_mem[w_idx][8*b +: 8] <= r_dat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= IDLE;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      // Responses are single-cycle pulses. Read data is zero outside the ack cycle.
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      case (r_state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            r_adr   <= wb_adr_i;
            r_dat   <= wb_dat_i;
            r_sel   <= wb_sel_i;
            r_we    <= wb_we_i;
            r_ws    <= ws_i;
            r_state <= (ws_i != 4'd0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          // If the master withdraws, the transaction is dropped silently.
          if (!wb_cyc_i || !wb_stb_i) r_state <= IDLE;
          else if (r_ws == 4'd1)      r_state <= RESP;
          else                        r_ws    <= r_ws - 4'd1;
        end
        RESP: begin
          r_state <= IDLE;
          if (w_legal) begin
            r_ack <= 1'b1;
            if (r_we) begin
              if (r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end else begin
              r_rdata <= r_mem[w_idx];
              if (r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            end
          end else begin
            r_err <= 1'b1;
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wb_dat_o  = r_rdata;
  assign wb_ack_o  = r_ack;
  assign wb_err_o  = r_err;
  assign rd_cnt_o  = r_rd_cnt;
  assign wr_cnt_o  = r_wr_cnt;
  assign err_cnt_o = r_err_cnt;
endmodule

// File: tb/tb_wb_slave_mem.sv
// Testbench for wb_slave_mem. Directed scenarios are followed by randomized
// transfers. The reference model is a word array with per-byte valid flags
// and saturating expected counters.
module tb_wb_slave_mem;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          CW    = 4;
  localparam int          CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   adr, dat_w, dat_r;
  logic [3:0]    sel, ws;
  logic          we, cyc, stb, ack, err;
  logic [CW-1:0] rd_cnt, wr_cnt, err_cnt;

  always #5 clk = ~clk;

  wb_slave_mem #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .CNT_W(CW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w),
    .wb_dat_o(dat_r), .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc),
    .wb_stb_i(stb), .wb_ack_o(ack), .wb_err_o(err), .ws_i(ws),
    .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt), .err_cnt_o(err_cnt)
  );

  int n_chk = 0, n_err = 0;
  logic [31:0] mdl [DEPTH];
  logic [3:0]  kb  [DEPTH];
  int e_rd = 0, e_wr = 0, e_er = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic chk_cnts();
    chk("rd_cnt",  32'(rd_cnt),  32'(e_rd));
    chk("wr_cnt",  32'(wr_cnt),  32'(e_wr));
    chk("err_cnt", 32'(err_cnt), 32'(e_er));
  endtask

  // One bus transfer. If abort_after >= 0, stb is dropped after that many wait cycles.
  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input bit w, input int nws, input int abort_after);
    logic [31:0] off, m;
    bit          legal;
    int          idx;
    @(negedge clk);
    adr = a; dat_w = d; sel = s; we = w; ws = 4'(nws); cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    ws = 4'($urandom);  // must not affect the accepted transaction
    if (abort_after >= 0) begin
      repeat (abort_after) begin
        @(posedge clk); #1;
        chk("abort_wait", 32'({ack, err}), 32'd0);
      end
      stb = 1'b0;
      repeat (nws + 2) begin
        @(posedge clk); #1;
        chk("abort_quiet", 32'({ack, err}), 32'd0);
      end
      cyc = 1'b0;
      chk_cnts();
    end else begin
      for (int k = 1; k <= nws; k++) begin
        @(posedge clk); #1;
        chk("wait_quiet", 32'({ack, err}), 32'd0);
      end
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0;
      off   = a - BASE;
      legal = (off < 32'(4 * DEPTH)) && (s != 4'b0000);
      idx   = int'(off >> 2);
      if (!legal) begin
        chk("err_resp", 32'({ack, err}), 32'd1);
        chk("err_dat",  dat_r, 32'd0);
        e_er = sat(e_er);
      end else begin
        chk("ack_resp", 32'({ack, err}), 32'd2);
        if (w) begin
          for (int b = 0; b < 4; b++)
            if (s[b]) begin
              mdl[idx][8*b +: 8] = d[8*b +: 8];
              kb[idx][b] = 1'b1;
            end
          chk("wr_dat", dat_r, 32'd0);
          e_wr = sat(e_wr);
        end else begin
          m = {{8{kb[idx][3]}}, {8{kb[idx][2]}}, {8{kb[idx][1]}}, {8{kb[idx][0]}}};
          chk("rd_dat", dat_r & m, mdl[idx] & m);
          e_rd = sat(e_rd);
        end
      end
      @(posedge clk); #1;
      chk("pulse_end", 32'({ack, err}), 32'd0);
      chk("dat_idle", dat_r, 32'd0);
      chk_cnts();
    end
  endtask

  initial begin
    logic [31:0] ra;
    for (int i = 0; i < DEPTH; i++) begin mdl[i] = '0; kb[i] = 4'b0; end
    rst = 1'b1; adr = '0; dat_w = '0; sel = '0; we = 1'b0; ws = '0; cyc = 1'b0; stb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp", 32'({ack, err}), 32'd0);
    chk("rst_dat", dat_r, 32'd0);
    chk_cnts();
    @(negedge clk); rst = 1'b0;

    // Basic write then read, zero wait states.
    xfer(32'h10, 32'hDEAD_BEEF, 4'hF, 1, 0, -1);
    xfer(32'h10, 32'h0,         4'hF, 0, 0, -1);
    chk("wr_cnt_1", 32'(wr_cnt), 32'd1);
    chk("rd_cnt_1", 32'(rd_cnt), 32'd1);

    // Byte-lane write.
    xfer(32'h20, 32'h1122_3344, 4'hF,    1, 0, -1);
    xfer(32'h20, 32'hAABB_CCDD, 4'b0101, 1, 0, -1);
    xfer(32'h20, 32'h0,         4'hF,    0, 0, -1);
    chk("partial_mdl", mdl[8], 32'h11BB_33DD);

    // Wait states.
    xfer(32'h10, 32'h0, 4'hF, 0, 3, -1);

    // cyc without stb is not a request.
    @(negedge clk); cyc = 1'b1; stb = 1'b0;
    repeat (3) begin @(posedge clk); #1; chk("cyc_only", 32'({ack, err}), 32'd0); end
    cyc = 1'b0;

    // Illegal accesses: out-of-window read and a sel=0 write.
    xfer(BASE + 32'(4 * DEPTH), 32'h0, 4'hF, 0, 0, -1);
    xfer(32'h10, 32'h1234_5678, 4'h0, 1, 0, -1);
    chk("err_cnt_2", 32'(err_cnt), 32'd2);
    xfer(32'h10, 32'h0, 4'hF, 0, 0, -1);

    // Abort during wait states, then normal access.
    xfer(32'h20, 32'hFFFF_FFFF, 4'hF, 1, 5, 2);
    xfer(32'h20, 32'h0, 4'hF, 0, 1, -1);

    // Reset during the wait phase of a write.
    @(negedge clk);
    adr = 32'h10; dat_w = 32'h0BAD_F00D; sel = 4'hF; we = 1'b1; ws = 4'd6; cyc = 1'b1; stb = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_resp", 32'({ack, err}), 32'd0);
    e_rd = 0; e_wr = 0; e_er = 0;
    chk_cnts();
    @(negedge clk); rst = 1'b0;
    repeat (8) begin @(posedge clk); #1; chk("rst_mid_quiet", 32'({ack, err}), 32'd0); end
    xfer(32'h10, 32'h0, 4'hF, 0, 0, -1);
    xfer(32'h20, 32'h0, 4'hF, 0, 2, -1);

    // Randomized traffic; counters reach saturation along the way.
    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 15) == 0) ra = $urandom;
      else ra = BASE + 32'($urandom_range(0, 4 * DEPTH + 15));
      if ($urandom_range(0, 9) == 0)
        xfer(ra, $urandom, 4'($urandom_range(1, 15)), 1'($urandom), $urandom_range(3, 6), $urandom_range(0, 2));
      else
        xfer(ra, $urandom, ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom),
             1'($urandom), $urandom_range(0, 4), -1);
    end
    chk("rd_sat", 32'(rd_cnt), 32'(CMAX));
    chk("wr_sat", 32'(wr_cnt), 32'(CMAX));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
